seq_digit_comparator: RTL and testbench

Parametrised, iterative successor to the flat 32-bit signed less-than comparator. It compares two WIDTH-bit operands DIGIT bits per cycle, starting at the most significant digit, and stops at the first digit where the operands differ. It supports signed and unsigned modes and six relational operations. Valid/ready handshakes on both sides make it suitable for placement between operand buffers and a result consumer in the arithmetic benchmark datapaths.

---
 rtl/seq_digit_comparator.sv | 166 ++++++++++++++++
 tb/tb_seq_digit_comparator.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_digit_comparator.sv
// seq_digit_comparator: iterative MSB-first digit comparator
// with signed/unsigned modes, six relational ops and valid/ready handshakes.
module seq_digit_comparator #(
    parameter  int WIDTH = 32,
    parameter  int DIGIT = 4,
    localparam int NDIG  = WIDTH / DIGIT,
    localparam int CW    = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic             out_lt,
    output logic             out_eq,
    output logic [CW-1:0]    out_cycles,
    output logic             out_err
);

    localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("seq_digit_comparator: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [KW-1:0]     k_q, k_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic              lt_q, lt_d;
    logic              eq_q, eq_d;
    logic              res_q, res_d;
    logic              err_q, err_d;

    logic [DIGIT-1:0]  dig_a;
    logic [DIGIT-1:0]  dig_b;
    logic              dig_lt;
    logic              dig_eq;
    logic              res_n;
    logic              err_n;
    logic [CW-1:0]     cnt_n;

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            res_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: capture in IDLE, walk digits MSB-first in SCAN,
    // hold the result in DONE until the consumer takes it.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        res_d   = res_q;
        err_d   = err_q;

        dig_a  = DIGIT'(a_q >> (int'(k_q) * DIGIT));
        dig_b  = DIGIT'(b_q >> (int'(k_q) * DIGIT));
        dig_lt = (dig_a < dig_b);
        dig_eq = (dig_a == dig_b);
        cnt_n  = cnt_q + CW'(1);

        res_n = 1'b0;
        err_n = 1'b0;
        unique case (op_q)
            3'b000:  res_n = dig_lt;
            3'b001:  res_n = dig_lt | dig_eq;
            3'b010:  res_n = ~dig_lt & ~dig_eq;
            3'b011:  res_n = ~dig_lt;
            3'b100:  res_n = dig_eq;
            3'b101:  res_n = ~dig_eq;
            default: err_n = 1'b1;
        endcase

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Flipping the sign bit maps two's complement onto unsigned order.
                    a_d            = in_a;
                    b_d            = in_b;
                    a_d[WIDTH-1]   = in_a[WIDTH-1] ^ in_signed;
                    b_d[WIDTH-1]   = in_b[WIDTH-1] ^ in_signed;
                    op_d           = in_op;
                    k_d            = KW'(NDIG - 1);
                    cnt_d          = '0;
                    state_d        = SCAN;
                end
            end
            SCAN: begin
                cnt_d = cnt_n;
                if (!dig_eq || k_q == '0) begin
                    lt_d    = dig_lt;
                    eq_d    = dig_eq;
                    cyc_d   = cnt_n;
                    res_d   = res_n;
                    err_d   = err_n;
                    state_d = DONE;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;
    assign out_lt     = lt_q;
    assign out_eq     = eq_q;
    assign out_cycles = cyc_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_seq_digit_comparator.sv
// tb_seq_digit_comparator: directed and randomized checks of the
// digit-serial comparator at 32/4 and 8/1 against a reference model.
module tb_seq_digit_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        iv_w = 0, ir_w, sg_w = 0, ov_w, or_w = 0;
    logic [31:0] a_w = 0, b_w = 0;
    logic [2:0]  op_w = 0;
    logic        res_w, lt_w, eq_w, err_w;
    logic [3:0]  cyc_w;

    logic        iv_n = 0, ir_n, sg_n = 0, ov_n, or_n = 0;
    logic [7:0]  a_n = 0, b_n = 0;
    logic [2:0]  op_n = 0;
    logic        res_n, lt_n, eq_n, err_n;
    logic [3:0]  cyc_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_digit_comparator #(.WIDTH(32), .DIGIT(4)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(iv_w), .in_ready(ir_w),
        .in_a(a_w), .in_b(b_w), .in_signed(sg_w), .in_op(op_w),
        .out_valid(ov_w), .out_ready(or_w),
        .out_result(res_w), .out_lt(lt_w), .out_eq(eq_w),
        .out_cycles(cyc_w), .out_err(err_w)
    );

    seq_digit_comparator #(.WIDTH(8), .DIGIT(1)) dut_n (
        .clk(clk), .rst(rst),
        .in_valid(iv_n), .in_ready(ir_n),
        .in_a(a_n), .in_b(b_n), .in_signed(sg_n), .in_op(op_n),
        .out_valid(ov_n), .out_ready(or_n),
        .out_result(res_n), .out_lt(lt_n), .out_eq(eq_n),
        .out_cycles(cyc_n), .out_err(err_n)
    );

    // Reference: numeric compare, first differing digit from the top.
    task automatic ref_model(input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic [2:0] op,
                             input int w, input int d,
                             output logic res, output logic lt,
                             output logic eq, output logic err,
                             output int cyc);
        longint va, vb;
        logic [31:0] x;
        int p;
        va = longint'(a);
        vb = longint'(b);
        if (s && a[w-1]) va = va - (longint'(1) << w);
        if (s && b[w-1]) vb = vb - (longint'(1) << w);
        lt = (va < vb);
        eq = (va == vb);
        x = a ^ b;
        p = -1;
        for (int i = 0; i < w; i++) if (x[i]) p = i;
        cyc = (p < 0) ? w / d : w / d - p / d;
        err = 1'b0;
        res = 1'b0;
        case (op)
            3'd0: res = lt;
            3'd1: res = lt || eq;
            3'd2: res = !lt && !eq;
            3'd3: res = !lt;
            3'd4: res = eq;
            3'd5: res = !eq;
            default: err = 1'b1;
        endcase
    endtask

    task automatic do_op_w(input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [2:0] op,
                           output int lat);
        a_w = a; b_w = b; sg_w = s; op_w = op; iv_w = 1;
        lat = 0;
        do begin
            @(posedge clk); lat++; #1; iv_w = 0;
        end while (!ov_w && lat < 64);
    endtask

    task automatic do_op_n(input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [2:0] op,
                           output int lat);
        a_n = a; b_n = b; sg_n = s; op_n = op; iv_n = 1;
        lat = 0;
        do begin
            @(posedge clk); lat++; #1; iv_n = 0;
        end while (!ov_n && lat < 64);
    endtask

    task automatic consume_w();
        or_w = 1; @(posedge clk); #1; or_w = 0;
    endtask

    task automatic consume_n();
        or_n = 1; @(posedge clk); #1; or_n = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        #12;
        checks++;
        if ({ir_w, ov_w, res_w, lt_w, eq_w, cyc_w, err_w} !== 10'b1_0_0_0_0_0000_0) begin
            errors++;
            $display("FAIL reset_w: got rdy=%b v=%b r=%b lt=%b eq=%b cyc=%0d err=%b, want rdy=1 rest 0",
                     ir_w, ov_w, res_w, lt_w, eq_w, cyc_w, err_w);
        end
        checks++;
        if ({ir_n, ov_n, res_n, lt_n, eq_n, cyc_n, err_n} !== 10'b1_0_0_0_0_0000_0) begin
            errors++;
            $display("FAIL reset_n: got rdy=%b v=%b r=%b lt=%b eq=%b cyc=%0d err=%b, want rdy=1 rest 0",
                     ir_n, ov_n, res_n, lt_n, eq_n, cyc_n, err_n);
        end
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_signed_lt();
        int lat;
        do_op_w(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'd0, lat);
        checks++;
        if ({res_w, lt_w, eq_w, cyc_w, err_w} !== 8'b1_1_0_0001_0 || lat != 2) begin
            errors++;
            $display("FAIL signed_lt: got r=%b lt=%b eq=%b cyc=%0d err=%b lat=%0d, want r=1 lt=1 eq=0 cyc=1 err=0 lat=2",
                     res_w, lt_w, eq_w, cyc_w, err_w, lat);
        end
        consume_w();
        checks++;
        if (ov_w !== 1'b0 || ir_w !== 1'b1) begin
            errors++;
            $display("FAIL consume: got v=%b rdy=%b, want v=0 rdy=1", ov_w, ir_w);
        end
    endtask

    task automatic test_unsigned_and_gt();
        int lat;
        do_op_w(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'd0, lat);
        checks++;
        if ({res_w, lt_w, cyc_w} !== 6'b0_0_0001 || lat != 2) begin
            errors++;
            $display("FAIL unsigned_lt: got r=%b lt=%b cyc=%0d lat=%0d, want r=0 lt=0 cyc=1 lat=2",
                     res_w, lt_w, cyc_w, lat);
        end
        consume_w();
        do_op_w(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'd2, lat);
        checks++;
        if ({res_w, lt_w, eq_w} !== 3'b0_1_0) begin
            errors++;
            $display("FAIL signed_gt: got r=%b lt=%b eq=%b, want r=0 lt=1 eq=0",
                     res_w, lt_w, eq_w);
        end
        consume_w();
    endtask

    task automatic test_eq_ne();
        int lat;
        do_op_w(32'h1234_5678, 32'h1234_5678, 1'b0, 3'd4, lat);
        checks++;
        if ({res_w, eq_w, lt_w, cyc_w} !== 7'b1_1_0_1000 || lat != 9) begin
            errors++;
            $display("FAIL eq: got r=%b eq=%b lt=%b cyc=%0d lat=%0d, want r=1 eq=1 lt=0 cyc=8 lat=9",
                     res_w, eq_w, lt_w, cyc_w, lat);
        end
        consume_w();
        do_op_w(32'h1234_5678, 32'h1234_5678, 1'b0, 3'd5, lat);
        checks++;
        if ({res_w, eq_w} !== 2'b0_1) begin
            errors++;
            $display("FAIL ne: got r=%b eq=%b, want r=0 eq=1", res_w, eq_w);
        end
        consume_w();
    endtask

    task automatic test_hold();
        int lat;
        logic [7:0] snap;
        do_op_w(32'h0000_0010, 32'h0000_0011, 1'b0, 3'd1, lat);
        checks++;
        if ({res_w, lt_w, eq_w, cyc_w} !== 7'b1_1_0_1000 || lat != 9) begin
            errors++;
            $display("FAIL le_digit0: got r=%b lt=%b eq=%b cyc=%0d lat=%0d, want r=1 lt=1 eq=0 cyc=8 lat=9",
                     res_w, lt_w, eq_w, cyc_w, lat);
        end
        snap = {res_w, lt_w, eq_w, cyc_w, err_w};
        // Inputs wiggle during the stall and must be ignored.
        iv_w = 1; a_w = 32'hDEAD_BEEF; op_w = 3'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({res_w, lt_w, eq_w, cyc_w, err_w} !== snap || ov_w !== 1'b1 || ir_w !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: got outs=%b v=%b rdy=%b, want outs=%b v=1 rdy=0",
                         i, {res_w, lt_w, eq_w, cyc_w, err_w}, ov_w, ir_w, snap);
            end
        end
        iv_w = 0;
        consume_w();
    endtask

    task automatic test_reserved_and_reset();
        int lat;
        do_op_w(32'd3, 32'd5, 1'b0, 3'b110, lat);
        checks++;
        if ({err_w, res_w, lt_w, eq_w, cyc_w} !== 8'b1_0_1_0_1000) begin
            errors++;
            $display("FAIL reserved: got err=%b r=%b lt=%b eq=%b cyc=%0d, want err=1 r=0 lt=1 eq=0 cyc=8",
                     err_w, res_w, lt_w, eq_w, cyc_w);
        end
        consume_w();
        a_w = 0; b_w = 0; op_w = 3'd4; sg_w = 0; iv_w = 1;
        @(posedge clk); #1; iv_w = 0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (ir_w !== 1'b0 || ov_w !== 1'b0) begin
            errors++;
            $display("FAIL mid_scan: got rdy=%b v=%b, want rdy=0 v=0", ir_w, ov_w);
        end
        #1; rst = 1;
        #1;
        checks++;
        if (ov_w !== 1'b0 || ir_w !== 1'b1 || cyc_w !== 4'd0) begin
            errors++;
            $display("FAIL async_rst: got v=%b rdy=%b cyc=%0d, want v=0 rdy=1 cyc=0", ov_w, ir_w, cyc_w);
        end
        #2; rst = 0;
        @(posedge clk); #1;
        do_op_w(32'h0000_1000, 32'h0000_2000, 1'b0, 3'd3, lat);
        checks++;
        if ({res_w, lt_w, eq_w, cyc_w} !== 7'b0_1_0_0101 || lat != 6) begin
            errors++;
            $display("FAIL after_rst: got r=%b lt=%b eq=%b cyc=%0d lat=%0d, want r=0 lt=1 eq=0 cyc=5 lat=6",
                     res_w, lt_w, eq_w, cyc_w, lat);
        end
        consume_w();
    endtask

    task automatic test_narrow();
        int lat;
        do_op_n(8'h7F, 8'h80, 1'b1, 3'd3, lat);
        checks++;
        if ({res_n, lt_n, eq_n, cyc_n} !== 7'b1_0_0_0001 || lat != 2) begin
            errors++;
            $display("FAIL narrow_ge: got r=%b lt=%b eq=%b cyc=%0d lat=%0d, want r=1 lt=0 eq=0 cyc=1 lat=2",
                     res_n, lt_n, eq_n, cyc_n, lat);
        end
        consume_n();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic s, r, l, e, er;
        logic [2:0] op;
        int c, lat;
        for (int i = 0; i < 1500; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = a;
                2: b = a ^ (32'd1 << $urandom_range(0, 31));
                default: b = a ^ ($urandom >> $urandom_range(0, 31));
            endcase
            s = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            ref_model(a, b, s, op, 32, 4, r, l, e, er, c);
            do_op_w(a, b, s, op, lat);
            checks++;
            if ({res_w, lt_w, eq_w, err_w, cyc_w} !== {r, l, e, er, 4'(c)} || lat != c + 1) begin
                errors++;
                $display("FAIL rand_w a=%h b=%h s=%b op=%0d: got r=%b lt=%b eq=%b err=%b cyc=%0d lat=%0d, want %b %b %b %b %0d %0d",
                         a, b, s, op, res_w, lt_w, eq_w, err_w, cyc_w, lat, r, l, e, er, c, c + 1);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            consume_w();
        end
        for (int i = 0; i < 1500; i++) begin
            a = {24'd0, 8'($urandom)};
            b = ($urandom_range(0, 3) == 0) ? a : {24'd0, 8'($urandom)};
            s = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            ref_model(a, b, s, op, 8, 1, r, l, e, er, c);
            do_op_n(a[7:0], b[7:0], s, op, lat);
            checks++;
            if ({res_n, lt_n, eq_n, err_n, cyc_n} !== {r, l, e, er, 4'(c)} || lat != c + 1) begin
                errors++;
                $display("FAIL rand_n a=%h b=%h s=%b op=%0d: got r=%b lt=%b eq=%b err=%b cyc=%0d lat=%0d, want %b %b %b %b %0d %0d",
                         a[7:0], b[7:0], s, op, res_n, lt_n, eq_n, err_n, cyc_n, lat, r, l, e, er, c, c + 1);
            end
            consume_n();
        end
    endtask

    initial begin
        test_reset();
        test_signed_lt();
        test_unsigned_and_gt();
        test_eq_ne();
        test_hold();
        test_reserved_and_reset();
        test_narrow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
